// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory-bus initiator: default widths, FSM state set and
// the queued command record.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_VRD   = 3'd5,
    ST_VWAIT = 3'd6
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Command FIFO holding mem_cmd_t records; DEPTH must be a power of two so the
// pointers wrap by plain overflow.
module mem_cmd_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  mem_cmd_t                 din,
  input  logic                     pop,
  output mem_cmd_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  mem_cmd_t        store [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  // full/empty come from the registered count, so a same-cycle pop never frees a slot for push
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the 32x8 memory bus: queues commands, sequences strobes, returns read data.
// Define MEM_WR_VERIFY_EN to read back every write and flag mismatches on verify_err.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CMD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              verify_err
);

  state_e                     state;
  mem_cmd_t                   cmd_in;
  mem_cmd_t                   head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(CMD_DEPTH):0] fifo_count;
  logic                       pop;

  // mem_cmd_t fields are sized by the package defaults; ADDR_W/DATA_W must match them
  assign cmd_in    = {cmd_write, cmd_addr, cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  mem_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            mem_addr <= head.addr;
            if (head.write) begin
              mem_data_in <= head.wdata;
              mem_write   <= 1'b1;
              state       <= ST_WRITE;
            end else begin
              mem_read <= 1'b1;
              state    <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
`ifdef MEM_WR_VERIFY_EN
          mem_read <= 1'b1;
          state    <= ST_VRD;
`else
          state <= ST_IDLE;
`endif
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          rsp_data  <= mem_data_out;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
`ifdef MEM_WR_VERIFY_EN
        ST_VRD:   state <= ST_VWAIT;
        ST_VWAIT: state <= ST_IDLE;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_WR_VERIFY_EN
  // mem_data_in still holds the written byte while the verify read returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_err <= 1'b0;
    end else if (state == ST_VWAIT && mem_data_out != mem_data_in) begin
      verify_err <= 1'b1;
    end
  end
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 32x8 memory responder model.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_write, rsp_ready;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_ready, rsp_valid, mem_read, mem_write, busy, verify_err;
  logic [7:0] rsp_data, mem_data_in;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .verify_err   (verify_err)
  );

  // memory responder: write sampled at the edge, read data one cycle after the read edge
  logic [7:0] mem_arr [32];
  logic [7:0] corrupt;
`ifdef MEM_WR_VERIFY_EN
  assign corrupt = (mem_addr == 5'd7) ? 8'h81 : 8'h00;
`else
  assign corrupt = 8'h00;
`endif
  initial begin
    mem_data_out = 8'h00;
    for (int i = 0; i < 32; i++) mem_arr[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out <= mem_arr[mem_addr] ^ corrupt;
  end

  int         rd_while_rsp = 0;
  int         both_hi = 0;
  int         rd_cnt = 0;
  logic [4:0] wr_log [$];
  always @(negedge clk) begin
    if (mem_read && rsp_valid) rd_while_rsp++;
    if (mem_read && mem_write) both_hi++;
    if (mem_read) rd_cnt++;
    if (mem_write) wr_log.push_back(mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got=timeout want=event", name);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 50) begin
      cyc(1);
      n++;
    end
    if (!cmd_ready) timeout("send_ready");
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [7:0] exp);
    int n = 0;
    while (!rsp_valid && n < 30) begin
      cyc(1);
      n++;
    end
    if (!rsp_valid) timeout(name);
    else chk(name, rsp_data, exp);
  endtask

  task automatic wait_wr(input string name, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    while (!mem_write && n < 30) begin
      cyc(1);
      n++;
    end
    if (!mem_write) timeout(name);
    else begin
      chk({name, "_addr"}, mem_addr, a);
      chk({name, "_data"}, mem_data_in, d);
    end
  endtask

  typedef struct {
    logic       write;
    logic [4:0] addr;
    logic [7:0] data;
  } vec_t;
  vec_t vecs [9];

  logic [4:0] rd_addr [5];
  logic [7:0] rd_exp  [5];

  initial begin
    vecs[0] = '{1'b1, 5'd10, 8'h5A};
    vecs[1] = '{1'b1, 5'd20, 8'hC3};
    vecs[2] = '{1'b0, 5'd10, 8'h5A};
    vecs[3] = '{1'b0, 5'd20, 8'hC3};
    vecs[4] = '{1'b1, 5'd0,  8'hFF};
    vecs[5] = '{1'b0, 5'd0,  8'hFF};
    vecs[6] = '{1'b1, 5'd31, 8'h01};
    vecs[7] = '{1'b0, 5'd31, 8'h01};
    vecs[8] = '{1'b0, 5'd3,  8'hA5};
    rd_addr = '{5'd10, 5'd20, 5'd0, 5'd31, 5'd3};
    rd_exp  = '{8'h5A, 8'hC3, 8'hFF, 8'h01, 8'hA5};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    #23 rst_n = 1'b1;
    cyc(5);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_read, mem_write, rsp_valid, verify_err}, 0);
    chk("rst_buses", {mem_addr, mem_data_in, rsp_data}, 0);

    // write A5@3 then read @3, cycle-exact
    rsp_ready = 1'b1;
    send(1'b1, 5'd3, 8'hA5);
    chk("w_e0_strobe", mem_write, 0);
    chk("w_e0_busy", busy, 1);
    cyc(1);
    chk("w_e1_strobe", mem_write, 1);
    chk("w_e1_addr", mem_addr, 3);
    chk("w_e1_data", mem_data_in, 8'hA5);
    cyc(1);
    chk("w_e2_strobe", mem_write, 0);
    cyc(3);
    send(1'b0, 5'd3, 8'h00);
    chk("r_e0_read", mem_read, 0);
    cyc(1);
    chk("r_e1_read", mem_read, 1);
    chk("r_e1_addr", mem_addr, 3);
    cyc(1);
    chk("r_e2_read", mem_read, 0);
    chk("r_e2_valid", rsp_valid, 0);
    cyc(1);
    chk("r_e3_valid", rsp_valid, 1);
    chk("r_e3_data", rsp_data, 8'hA5);
    cyc(1);
    chk("r_e4_valid", rsp_valid, 0);
    cyc(4);

    foreach (vecs[i]) begin
      send(vecs[i].write, vecs[i].addr, vecs[i].data);
      if (vecs[i].write) begin
        wait_wr($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].data);
        cyc(4);
      end else begin
        wait_rsp($sformatf("vec%0d_rsp", i), vecs[i].data);
        cyc(1);
        chk($sformatf("vec%0d_consumed", i), rsp_valid, 0);
      end
    end
    cyc(3);

    // back-pressure: five reads with the consumer stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, rd_addr[i], 8'h00);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    cyc(6);
    chk("bp_hold_ready", cmd_ready, 0);
    chk("bp_hold_data", rsp_data, 8'h5A);
    chk("bp_no_read", mem_read, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp($sformatf("bp_rsp%0d", i), rd_exp[i]);
      cyc(1);
    end
    cyc(2);
    chk("bp_drained_ready", cmd_ready, 1);
    chk("bp_drained_busy", busy, 0);
    chk("bp_read_during_rsp", rd_while_rsp, 0);

    // back-to-back writes at the address extremes
    wr_log.delete();
    rd_cnt = 0;
    send(1'b1, 5'd31, 8'h66);
    send(1'b1, 5'd0, 8'h99);
    cyc(12);
    chk("b2b_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("b2b_addr0", wr_log[0], 31);
      chk("b2b_addr1", wr_log[1], 0);
    end
`ifdef MEM_WR_VERIFY_EN
    chk("b2b_reads", rd_cnt, 2);
`else
    chk("b2b_reads", rd_cnt, 0);
`endif

    // reset while a read strobe is on the bus, with a write still queued
    send(1'b0, 5'd10, 8'h00);
    send(1'b1, 5'd10, 8'h77);
    chk("ar_pre_read", mem_read, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_read", mem_read, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cmd_ready", cmd_ready, 1);
    #3 rst_n = 1'b1;
    cyc(2);
    send(1'b0, 5'd10, 8'h00);
    wait_rsp("ar_after_rsp", 8'h5A);
    cyc(3);

`ifdef MEM_WR_VERIFY_EN
    chk("ve_clear", verify_err, 0);
    send(1'b1, 5'd7, 8'h3C);
    cyc(8);
    chk("ve_set", verify_err, 1);
    send(1'b0, 5'd3, 8'h00);
    wait_rsp("ve_rsp", 8'hA5);
    cyc(4);
    chk("ve_sticky", verify_err, 1);
`else
    chk("verify_err_tied", verify_err, 0);
`endif
    chk("never_both_strobes", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
